// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential word reads, queues returned words with their PCs.
// Define MISALIGN_TRAP_EN to trap misaligned redirects; otherwise redirect_addr[1:0] is masked.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_out,
  output logic [31:0] ins_pc,
  output logic        fetch_fault
);

  localparam int unsigned AW = $clog2(DEPTH);

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t        state;
  logic [31:0]   fetch_addr;
  logic [31:0]   rsp_pc;
  logic [3:0]    inflight;
  logic [3:0]    drop;
  logic [AW:0]   count;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [31:0]   q_data [DEPTH];
  logic [31:0]   q_pc   [DEPTH];

  logic          grant;
  logic          push;
  logic          pop;
  logic [3:0]    inflight_next;
  logic [31:0]   redir_addr;

`ifdef MISALIGN_TRAP_EN
  assign redir_addr  = redirect_addr;
  assign fetch_fault = (state == FAULT);
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_addr[1:0];
  assign redir_addr      = {redirect_addr[31:2], 2'b00};
  assign fetch_fault     = 1'b0;
`endif

  // Credit rule: every in-flight read has a guaranteed queue slot, so pushes never overflow.
  assign mem_req  = (state == RUN) &&
                    ((32'(count) + 32'(inflight)) < DEPTH) &&
                    (32'(inflight) < MAX_OUT);
  assign mem_addr = fetch_addr;
  assign grant    = mem_req && mem_gnt;

  assign ins_valid = (count != '0);
  assign ins_out   = ins_valid ? q_data[rptr] : 32'd0;
  assign ins_pc    = ins_valid ? q_pc[rptr]   : 32'd0;

  assign push          = mem_rvalid && (drop == 4'd0) && !redirect;
  assign pop           = ins_valid && ins_ready && !redirect;
  assign inflight_next = inflight + {3'd0, grant} - {3'd0, mem_rvalid};

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      fetch_addr <= RESET_PC;
      rsp_pc     <= RESET_PC;
      inflight   <= 4'd0;
      drop       <= 4'd0;
      count      <= '0;
      wptr       <= '0;
      rptr       <= '0;
    end else begin
      inflight <= inflight_next;
      if (redirect) begin
        // Everything still outstanding after this cycle belongs to the old stream.
        fetch_addr <= redir_addr;
        rsp_pc     <= redir_addr;
        drop       <= inflight_next;
        count      <= '0;
        wptr       <= '0;
        rptr       <= '0;
`ifdef MISALIGN_TRAP_EN
        if (redirect_addr[1:0] != 2'b00)
          state <= FAULT;
        else
          state <= fetch_en ? RUN : IDLE;
`else
        state <= fetch_en ? RUN : IDLE;
`endif
      end else begin
        if (grant)
          fetch_addr <= fetch_addr + 32'd4;
        if (mem_rvalid && (drop != 4'd0))
          drop <= drop - 4'd1;
        if (push) begin
          wptr   <= wptr + AW'(1);
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop)
          rptr <= rptr + AW'(1);
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
`ifdef MISALIGN_TRAP_EN
        if (state != FAULT)
          state <= fetch_en ? RUN : IDLE;
`else
        state <= fetch_en ? RUN : IDLE;
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      q_data[wptr] <= mem_rdata;
      q_pc[wptr]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: in-order memory model plus expected-instruction queue.
// Build with MISALIGN_TRAP_EN defined to exercise the misaligned-redirect trap.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK;
  logic        Reset;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_out;
  logic [31:0] ins_pc;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_q [$];
  logic [31:0] exp_pc_q [$];
  logic [31:0] exp_ins_q [$];
  logic [31:0] gnt_log [$];
  logic [31:0] exp_addr = RESET_PC;
  bit          mem_hold = 1'b0;
  int          gnt_cnt = 0;
  int          pop_cnt = 0;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(4), .MAX_OUT(4)) dut (
    .CLK(CLK), .Reset(Reset), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_addr(redirect_addr), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_out(ins_out),
    .ins_pc(ins_pc), .fetch_fault(fetch_fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] fetch_target(input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return a;
`else
    return {a[31:2], 2'b00};
`endif
  endfunction

  // Memory model: answers each granted read in order, one cycle after the grant.
  always @(posedge CLK) begin
    #1;
    if (Reset && !mem_hold && mem_q.size() > 0) begin
      mem_rdata  = mem_word(mem_q.pop_front());
      mem_rvalid = 1'b1;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;
    end
  end

  // Scoreboard: expected words pushed at grant, compared when the decoder pops them.
  always @(negedge CLK) begin
    if (!Reset) begin
      mem_q.delete();
      exp_pc_q.delete();
      exp_ins_q.delete();
      exp_addr = RESET_PC;
    end else begin
      if (mem_req && mem_gnt) begin
        checks++;
        if (mem_addr !== exp_addr) begin
          errors++;
          $display("[TB] FAIL grant_addr got %h expected %h", mem_addr, exp_addr);
        end
        gnt_log.push_back(mem_addr);
        mem_q.push_back(mem_addr);
        gnt_cnt++;
        if (!redirect) begin
          exp_pc_q.push_back(exp_addr);
          exp_ins_q.push_back(mem_word(exp_addr));
        end
        exp_addr = exp_addr + 32'd4;
      end
      if (ins_valid && ins_ready && !redirect) begin
        checks++;
        pop_cnt++;
        if (exp_pc_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_pop got pc %h ins %h expected none", ins_pc, ins_out);
        end else begin
          logic [31:0] epc;
          logic [31:0] eins;
          epc  = exp_pc_q.pop_front();
          eins = exp_ins_q.pop_front();
          if (ins_pc !== epc || ins_out !== eins) begin
            errors++;
            $display("[TB] FAIL pop got pc %h ins %h expected pc %h ins %h",
                     ins_pc, ins_out, epc, eins);
          end
        end
      end
      if (redirect) begin
        exp_pc_q.delete();
        exp_ins_q.delete();
        exp_addr = fetch_target(redirect_addr);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic drain();
    bit done;
    fetch_en  = 1'b0;
    ins_ready = 1'b1;
    mem_gnt   = 1'b1;
    mem_hold  = 1'b0;
    redirect  = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      done = (exp_pc_q.size() == 0) && (mem_q.size() == 0) && !mem_rvalid &&
             !ins_valid && !mem_req;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL drain got pending %0d expected 0", exp_pc_q.size() + mem_q.size());
    end
    ins_ready = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_addr = 32'd0;
    mem_gnt = 1'b0; ins_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) step();
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== RESET_PC || ins_valid !== 1'b0 ||
        ins_out !== 32'd0 || ins_pc !== 32'd0 || fetch_fault !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset got req %b addr %h v %b ins %h pc %h flt %b expected 0 %h 0 0 0 0",
               mem_req, mem_addr, ins_valid, ins_out, ins_pc, fetch_fault, RESET_PC);
    end
    Reset = 1'b1;
    step();
  endtask

  task automatic test_sequential();
    int p0;
    gnt_log.delete();
    p0 = pop_cnt;
    fetch_en = 1'b1; mem_gnt = 1'b1; ins_ready = 1'b1;
    repeat (20) step();
    checks++;
    if (gnt_log.size() < 3 || gnt_log[0] !== 32'h0 || gnt_log[1] !== 32'h4 ||
        gnt_log[2] !== 32'h8) begin
      errors++;
      $display("[TB] FAIL seq_addrs got %0d grants expected 0,4,8 first", gnt_log.size());
    end
    checks++;
    if (pop_cnt - p0 < 12) begin
      errors++;
      $display("[TB] FAIL seq_throughput got %0d pops expected >=12", pop_cnt - p0);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int g0;
    g0 = gnt_cnt;
    fetch_en = 1'b1; mem_gnt = 1'b1; ins_ready = 1'b0;
    repeat (10) step();
    checks++;
    if (gnt_cnt - g0 !== 4 || mem_req !== 1'b0 || ins_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_stop got grants %0d req %b expected 4 0", gnt_cnt - g0, mem_req);
    end
    ins_ready = 1'b1;
    step();
    ins_ready = 1'b0;
    repeat (6) step();
    checks++;
    if (gnt_cnt - g0 !== 5 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL one_pop_refill got grants %0d req %b expected 5 0", gnt_cnt - g0, mem_req);
    end
    drain();
  endtask

  task automatic test_redirect_drop();
    int g0;
    bit seen;
    g0 = gnt_cnt;
    mem_hold = 1'b1; ins_ready = 1'b0; fetch_en = 1'b1; mem_gnt = 1'b1;
    for (int i = 0; i < 10 && (gnt_cnt - g0) < 3; i++) step();
    mem_gnt = 1'b0;
    checks++;
    if (gnt_cnt - g0 !== 3) begin
      errors++;
      $display("[TB] FAIL inflight_setup got %0d grants expected 3", gnt_cnt - g0);
    end
    redirect = 1'b1; redirect_addr = 32'h40;
    step();
    redirect = 1'b0; mem_hold = 1'b0; mem_gnt = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = ins_valid;
    end
    checks++;
    if (!seen || ins_pc !== 32'h40 || ins_out !== mem_word(32'h40)) begin
      errors++;
      $display("[TB] FAIL redirect_first got v %b pc %h ins %h expected 1 00000040 %h",
               seen, ins_pc, ins_out, mem_word(32'h40));
    end
    drain();
  endtask

  task automatic test_gnt_stall();
    logic [31:0] want;
    fetch_en = 1'b1; mem_gnt = 1'b0; ins_ready = 1'b1;
    step();
    want = exp_addr;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== want || ins_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL gnt_stall got req %b addr %h v %b expected 1 %h 0",
                 mem_req, mem_addr, ins_valid, want);
      end
    end
    drain();
  endtask

  task automatic test_wrap();
    int g0;
    gnt_log.delete();
    g0 = gnt_cnt;
    fetch_en = 1'b0; redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0; fetch_en = 1'b1; mem_gnt = 1'b1; ins_ready = 1'b1;
    for (int i = 0; i < 10 && (gnt_cnt - g0) < 2; i++) step();
    mem_gnt = 1'b0;
    checks++;
    if (gnt_log.size() < 2 || gnt_log[0] !== 32'hFFFF_FFFC || gnt_log[1] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL wrap got %0d grants expected FFFFFFFC then 00000000", gnt_log.size());
    end
    drain();
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic test_fault();
    gnt_log.delete();
    fetch_en = 1'b1; redirect = 1'b1; redirect_addr = 32'h42; mem_gnt = 1'b1;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fetch_fault !== 1'b1 || mem_req !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fault_set got flt %b req %b expected 1 0", fetch_fault, mem_req);
      end
      step();
    end
    redirect = 1'b1; redirect_addr = 32'h80;
    step();
    redirect = 1'b0;
    checks++;
    if (fetch_fault !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fault_clear got %b expected 0", fetch_fault);
    end
    for (int i = 0; i < 5 && gnt_log.size() == 0; i++) step();
    checks++;
    if (gnt_log.size() == 0 || gnt_log[0] !== 32'h80) begin
      errors++;
      $display("[TB] FAIL fault_refetch got %0d grants expected first 00000080", gnt_log.size());
    end
    drain();
  endtask
`else
  task automatic test_mask();
    gnt_log.delete();
    fetch_en = 1'b0; redirect = 1'b1; redirect_addr = 32'h46;
    step();
    redirect = 1'b0; fetch_en = 1'b1; mem_gnt = 1'b1; ins_ready = 1'b1;
    for (int i = 0; i < 5 && gnt_log.size() == 0; i++) step();
    checks++;
    if (gnt_log.size() == 0 || gnt_log[0] !== 32'h44 || fetch_fault !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mask got %0d grants flt %b expected first 00000044 flt 0",
               gnt_log.size(), fetch_fault);
    end
    drain();
  endtask
`endif

  task automatic test_reset_mid();
    fetch_en = 1'b1; mem_gnt = 1'b1; ins_ready = 1'b0;
    repeat (4) step();
    Reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || ins_valid !== 1'b0 || mem_addr !== RESET_PC) begin
      errors++;
      $display("[TB] FAIL reset_mid got req %b v %b addr %h expected 0 0 %h",
               mem_req, ins_valid, mem_addr, RESET_PC);
    end
    fetch_en = 1'b0;
    repeat (2) step();
    Reset = 1'b1;
    repeat (3) step();
    checks++;
    if (ins_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_idle got v %b req %b expected 0 0", ins_valid, mem_req);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drop();
    test_gnt_stall();
    test_wrap();
`ifdef MISALIGN_TRAP_EN
    test_fault();
`else
    test_mask();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
